dice_scorer: RTL and testbench
==============================

DICE_SCORER -- requirements
Module: dice_scorer

Interface
REQ-001 SHALL have parameter TARGET, default 30, winning score (legal range 7..121).
REQ-002 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port state, input, 2, game state from the turn controller: 00 powerOff, 01 p1Turn, 10 p2Turn, 11 gameFinished.
REQ-005 SHALL have port roll_n, input, 1, active-low roll pushbutton, already synchronised to clk.
REQ-006 SHALL have port die, output, 3, last accepted die value 1..6; 0 means no roll yet.
REQ-007 SHALL have port p1_score, output, 7, player 1 accumulated score.
REQ-008 SHALL have port p2_score, output, 7, player 2 accumulated score.
REQ-009 SHALL have port roll_valid, output, 1, one-cycle pulse when a roll is accepted.
REQ-010 SHALL have port has_won, output, 1, sticky win flag, fed back to the turn controller.
REQ-011 SHALL have port winner, output, 2, 00 none, 01 player 1, 10 player 2.

Function
REQ-012 SHALL run a free-running face counter cycling 1,2,3,4,5,6,1,... and advancing every clock; it is 1 in the first cycle after reset deasserts.
REQ-013 SHALL register roll_n each cycle; a press is a falling edge: previous sample 1, current sample 0.
REQ-014 SHALL accept a press only when state is 01 or 10, has_won=0 and the lockout is clear.
REQ-015 SHALL, for a press accepted in cycle N, update die, the active player's score and roll_valid=1 in cycle N+1; the latched face is the counter value in cycle N.
REQ-016 SHALL add die to p1_score when state=01 and to p2_score when state=10; the other score is unchanged.
REQ-017 SHALL saturate each score at TARGET: new score = min(old + face, TARGET).
REQ-018 SHALL set has_won=1 and winner to the scoring player in the same cycle the score reaches TARGET; both hold until reset or state=00.
REQ-019 SHALL set a lockout on each accepted roll and clear it only when state differs from the state in which the roll was accepted; a held or re-pressed button cannot score twice in one turn.
REQ-020 SHALL ignore presses in states 00 and 11, and while has_won=1; roll_valid stays 0.
REQ-021 SHALL, while state=00, clear the following to 0 every cycle: scores, die, has_won, winner, roll_valid and lockout. The face counter keeps running.
REQ-022 SHALL treat a press coinciding with a state change using the state sampled in the press cycle.
REQ-023 SHALL keep roll_valid 0 except for the single cycle after an accepted press.

Reset
REQ-024 SHALL, with reset=1 at a rising edge, set die=0, p1_score=0, p2_score=0, roll_valid=0, has_won=0, winner=00, lockout clear, previous roll_n sample=1 and face counter=1.
REQ-025 SHALL let reset override all other inputs, including a press in the same cycle; a roll in progress is discarded.

Configuration
REQ-026 SHALL, when DICE_ONE_RESET_EN is defined, set the active player's score to 0 on an accepted roll of face 1 instead of adding; die still shows 1 and roll_valid still pulses.
REQ-027 SHALL, when DICE_ONE_RESET_EN is undefined, add face 1 like any other face.

Verification
REQ-028 Reset release, state=01, press in cycle 3 after release -> cycle 4: die=4, p1_score=4, roll_valid=1; cycle 5: roll_valid=0.
REQ-029 state=01, hold roll_n=0 for 20 cycles, then release and press again -> exactly one roll_valid pulse; p1_score changes once.
REQ-030 TARGET=30, p2_score=27, state=10, accepted face 5 -> p2_score=30, has_won=1, winner=10; a later press in state 10 is ignored.
REQ-031 Scores nonzero, state forced to 00 for one cycle -> next cycle: scores=0, die=0, has_won=0, winner=00.
REQ-032 Press in the same cycle as reset=1 -> all outputs at reset values; roll_valid never pulses.
REQ-033 DICE_ONE_RESET_EN defined, p1_score=12, accepted face 1 in state 01 -> p1_score=0, die=1, roll_valid=1; with the macro undefined -> p1_score=13.

Source files
------------

// File: rtl/dice_scorer.sv
// dice_scorer: roll capture, turn lockout and saturating scores for a two-player dice game.
// Optional DICE_ONE_RESET_EN: an accepted face 1 zeroes the active player's score.
module dice_scorer #(
    parameter int TARGET = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    input  logic       roll_n,
    output logic [2:0] die,
    output logic [6:0] p1_score,
    output logic [6:0] p2_score,
    output logic       roll_valid,
    output logic       has_won,
    output logic [1:0] winner
);
    localparam logic [7:0] TGT = 8'(TARGET);
    logic [2:0] face_q, face_d, die_q, die_d;
    logic [6:0] p1_q, p1_d, p2_q, p2_d, new_score;
    logic [7:0] sum;
    logic       roll_q, valid_q, valid_d, won_q, won_d, lock_q, lock_d;
    logic [1:0] winner_q, winner_d, lock_st_q, lock_st_d;
    logic       playing, locked, accept;
    always_comb begin
        playing = state == 2'b01 || state == 2'b10;
        // lockout lapses as soon as the state moves away from the rolling turn
        locked = lock_q && state == lock_st_q;
        accept = roll_q && !roll_n && playing && !won_q && !locked;
        face_d = face_q == 3'd6 ? 3'd1 : face_q + 3'd1;
        sum = {1'b0, state == 2'b01 ? p1_q : p2_q} + {5'b0, face_q};
`ifdef DICE_ONE_RESET_EN
        new_score = face_q == 3'd1 ? 7'd0 : sum >= TGT ? TGT[6:0] : sum[6:0];
`else
        new_score = sum >= TGT ? TGT[6:0] : sum[6:0];
`endif
        die_d = die_q;
        p1_d = p1_q;
        p2_d = p2_q;
        won_d = won_q;
        winner_d = winner_q;
        lock_d = locked;
        lock_st_d = lock_st_q;
        valid_d = accept;
        if (state == 2'b00) begin
            die_d = 3'd0;
            p1_d = 7'd0;
            p2_d = 7'd0;
            won_d = 1'b0;
            winner_d = 2'b00;
            lock_d = 1'b0;
        end else if (accept) begin
            die_d = face_q;
            p1_d = state == 2'b01 ? new_score : p1_q;
            p2_d = state == 2'b10 ? new_score : p2_q;
            won_d = new_score == TGT[6:0];
            winner_d = new_score == TGT[6:0] ? state : 2'b00;
            lock_d = 1'b1;
            lock_st_d = state;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            face_q <= 3'd1;
            roll_q <= 1'b1;
            die_q <= 3'd0;
            p1_q <= 7'd0;
            p2_q <= 7'd0;
            valid_q <= 1'b0;
            won_q <= 1'b0;
            winner_q <= 2'b00;
            lock_q <= 1'b0;
            lock_st_q <= 2'b00;
        end else begin
            face_q <= face_d;
            roll_q <= roll_n;
            die_q <= die_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
            valid_q <= valid_d;
            won_q <= won_d;
            winner_q <= winner_d;
            lock_q <= lock_d;
            lock_st_q <= lock_st_d;
        end
    end
    assign die = die_q;
    assign p1_score = p1_q;
    assign p2_score = p2_q;
    assign roll_valid = valid_q;
    assign has_won = won_q;
    assign winner = winner_q;
endmodule

// File: tb/tb_dice_scorer.sv
// tb_dice_scorer: directed game scenarios plus random play, checked against a behavioural model.
module tb_dice_scorer;
    localparam int TARGET = 30;
    logic       clk, reset, roll_n, roll_valid, has_won;
    logic [1:0] state, winner;
    logic [2:0] die;
    logic [6:0] p1_score, p2_score;
    int checks = 0, errors = 0;
    int m_face, m_prev, m_die, m_p1, m_p2, m_valid, m_won, m_win, m_lock, m_lockst;
    int m_add, m_new;
    bit m_ok = 0, m_locked, m_acc;

    dice_scorer #(.TARGET(TARGET)) dut (
        .clk(clk), .reset(reset), .state(state), .roll_n(roll_n), .die(die),
        .p1_score(p1_score), .p2_score(p2_score), .roll_valid(roll_valid),
        .has_won(has_won), .winner(winner)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // reference: game rules in plain integer arithmetic
    always_comb begin
        m_locked = m_lock != 0 && int'(state) == m_lockst;
        m_acc = m_prev == 1 && roll_n == 1'b0 && (state == 2'd1 || state == 2'd2) && m_won == 0 && !m_locked;
        m_add = (state == 2'd1 ? m_p1 : m_p2) + m_face;
        m_new = m_add > TARGET ? TARGET : m_add;
`ifdef DICE_ONE_RESET_EN
        if (m_face == 1) m_new = 0;
`endif
    end

    always @(posedge clk) begin
        if (reset) begin
            m_ok <= 1;
            m_face <= 1; m_prev <= 1; m_die <= 0; m_p1 <= 0; m_p2 <= 0;
            m_valid <= 0; m_won <= 0; m_win <= 0; m_lock <= 0; m_lockst <= 0;
        end else begin
            m_face <= m_face % 6 + 1;
            m_prev <= int'(roll_n);
            m_valid <= int'(m_acc);
            if (state == 2'd0) begin
                m_die <= 0; m_p1 <= 0; m_p2 <= 0; m_won <= 0; m_win <= 0; m_lock <= 0;
            end else if (m_acc) begin
                m_die <= m_face;
                if (state == 2'd1) m_p1 <= m_new; else m_p2 <= m_new;
                if (m_new == TARGET) begin m_won <= 1; m_win <= int'(state); end
                m_lock <= 1;
                m_lockst <= int'(state);
            end else if (!m_locked) m_lock <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            checks++;
            if ({29'b0, die} !== m_die || {25'b0, p1_score} !== m_p1 || {25'b0, p2_score} !== m_p2 ||
                {31'b0, roll_valid} !== m_valid || {31'b0, has_won} !== m_won || {30'b0, winner} !== m_win) begin
                errors++;
                $display("FAIL model t=%0t die %0d/%0d p1 %0d/%0d p2 %0d/%0d valid %0d/%0d won %0d/%0d winner %0d/%0d (got/want)",
                         $time, die, m_die, p1_score, m_p1, p2_score, m_p2, roll_valid, m_valid,
                         has_won, m_won, winner, m_win);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // switch turn, wait for the wanted face, then press once
    task automatic roll(input logic [1:0] st, input int f);
        state = st;
        roll_n = 1;
        tick(1);
        for (int i = 0; i < 6 && m_face != f; i++) tick(1);
        chk("roll_face", m_face, f);
        roll_n = 0;
        tick(1);
        roll_n = 1;
    endtask

    int pulses, p1_before;

    initial begin
        reset = 1; state = 2'b01; roll_n = 1;
        tick(2);
        chk("rst_die", die, 0);
        chk("rst_p1", p1_score, 0);
        chk("rst_p2", p2_score, 0);
        chk("rst_valid", roll_valid, 0);
        chk("rst_won", has_won, 0);
        chk("rst_winner", winner, 0);
        roll_n = 0;
        tick(1);
        chk("rst_press_valid", roll_valid, 0);
        chk("rst_press_die", die, 0);
        roll_n = 1;
        tick(1);
        reset = 0;
        tick(3);
        roll_n = 0;
        tick(1);
        chk("first_die", die, 4);
        chk("first_p1", p1_score, 4);
        chk("first_valid", roll_valid, 1);
        pulses = int'(roll_valid);
        tick(1);
        chk("first_valid_drop", roll_valid, 0);
        for (int i = 0; i < 19; i++) begin
            tick(1);
            pulses += int'(roll_valid);
        end
        roll_n = 1;
        tick(1);
        roll_n = 0;
        tick(1);
        pulses += int'(roll_valid);
        tick(1);
        pulses += int'(roll_valid);
        chk("hold_pulses", pulses, 1);
        chk("hold_p1", p1_score, 4);
        state = 2'b00;
        roll_n = 1;
        tick(1);
        chk("off_p1", p1_score, 0);
        roll(2'b01, 6); roll(2'b10, 6); roll(2'b01, 6); roll(2'b10, 6);
        chk("p1_twelve", p1_score, 12);
        roll(2'b01, 1);
        chk("one_die", die, 1);
        chk("one_valid", roll_valid, 1);
`ifdef DICE_ONE_RESET_EN
        chk("one_p1", p1_score, 0);
`else
        chk("one_p1", p1_score, 13);
`endif
        roll(2'b10, 6); roll(2'b01, 1); roll(2'b10, 6); roll(2'b01, 1); roll(2'b10, 3);
        chk("p2_27", p2_score, 27);
        roll(2'b01, 1);
        roll(2'b10, 5);
        chk("win_p2", p2_score, 30);
        chk("win_die", die, 5);
        chk("win_flag", has_won, 1);
        chk("win_who", winner, 2);
        p1_before = int'(p1_score);
        roll(2'b01, 2);
        chk("won_ignore_valid", roll_valid, 0);
        chk("won_ignore_p1", p1_score, p1_before);
        roll(2'b10, 4);
        chk("won_ignore_p2", p2_score, 30);
        chk("won_sticky", winner, 2);
        state = 2'b00;
        tick(1);
        chk("clr_p1", p1_score, 0);
        chk("clr_p2", p2_score, 0);
        chk("clr_die", die, 0);
        chk("clr_won", has_won, 0);
        chk("clr_winner", winner, 0);
        state = 2'b01;
        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 7) == 0) state = 2'($urandom_range(0, 3));
            roll_n = 1'($urandom_range(0, 1));
            tick(1);
        end
        reset = 0;
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
